// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding for the transmit and receive paths.
// Bit timing is derived from the 24 MHz system clock at 9600 baud.
package uart_pkg;

    localparam int unsigned CLK_HZ               = 24_000_000;
    localparam int unsigned BAUD                 = 9600;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are dropped.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed through a small byte FIFO.
// Frames run back-to-back when the buffer holds another byte at the end of a stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DIV_W-1:0]     div;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 bit_done;

    assign bit_done = (div == DIV_LAST);
    // Pop either from idle or on the last cycle of a stop bit, giving gapless frames.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
    assign tx_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    uart_byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TxD     <= STOP_LEVEL;
        end else begin
            case (state)
                IDLE: begin
                    TxD <= STOP_LEVEL;
                    if (fifo_pop) begin
                        shift <= fifo_head;
                        div   <= '0;
                        state <= START;
                        TxD   <= START_LEVEL;
                    end
                end
                START: begin
                    if (bit_done) begin
                        div     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        TxD     <= shift[0];
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                            TxD   <= STOP_LEVEL;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            TxD     <= shift[1];
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        div <= '0;
                        if (fifo_pop) begin
                            shift <= fifo_head;
                            state <= START;
                            TxD   <= START_LEVEL;
                        end else begin
                            state <= IDLE;
                            TxD   <= STOP_LEVEL;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TxD   <= STOP_LEVEL;
                end
            endcase
        end
    end

endmodule
